sid_audio_decimator: RTL and testbench
======================================

Name: sid_audio_decimator

Overview:
Sits directly upstream of the I2S serializer. Takes per-tick SID waveform samples, averages fixed-size blocks of them into a decimated 16-bit signed stream, and holds a frame-stable sample for the serializer. The serializer latches that sample on each LRCLK edge. The block also counts frames that had no new sample.

Parameters:
DECIM_LOG2, 4, log2 of input samples averaged per output sample (block size N = 2^DECIM_LOG2, legal 1..8)
INPUT_SIGNED, 0, 0 = i_sample is offset binary (SID native); 1 = i_sample is already two's complement
DCB_SHIFT, 8, DC-blocker pole shift (only used with the optional feature)

Ports:
clk_25mhz  input  1  system clock
rst_25mhz_n  input  1  reset, asynchronous, active-low
i_sample  input  16  raw SID waveform sample
i_sample_stb  input  1  one-cycle strobe, i_sample valid; always accepted, no back-pressure
i_frame_stb  input  1  one-cycle strobe from the serializer at each LRCLK edge
i_mute  input  1  level; forces the frame sample to zero
o_sample  output  16  latest decimated sample, two's complement
o_sample_stb  output  1  one-cycle pulse when o_sample updates
o_frame_sample  output  16  sample held stable for the serializer across a frame
o_underrun_cnt  output  8  saturating count of frame strobes with no fresh sample

Behaviour:
- Reset (async assert, sync release): accumulator, block counter, o_sample, o_sample_stb, o_frame_sample, o_underrun_cnt, fresh flag and DC-blocker state all go to 0.
- Input conversion, combinational:
  - INPUT_SIGNED=0: x = {~i_sample[15], i_sample[14:0]}.
  - INPUT_SIGNED=1: x = i_sample.
- Accumulator:
  - Signed, 16+DECIM_LOG2 bits. Block counter is DECIM_LOG2 bits. No overflow is possible.
  - On i_sample_stb with counter != N-1: acc += x; counter += 1.
  - On i_sample_stb with counter == N-1 (block complete):
    - o_sample <= (acc + x) >>> DECIM_LOG2 (arithmetic shift, truncation toward -inf).
    - acc <= 0; counter <= 0.
    - o_sample_stb = 1 on the following cycle only. Latency is 1 clock from the final strobe.
  - With no i_sample_stb, state holds.
- Fresh flag: set when o_sample updates; cleared on i_frame_stb.
- Frame latch on i_frame_stb:
  - o_frame_sample <= i_mute ? 0 : o_sample.
  - If the fresh flag is clear, o_underrun_cnt += 1, saturating at 255. The first frame strobe after reset counts as an underrun.
- Simultaneous events:
  - i_frame_stb in the same cycle that o_sample is being written: the frame latch takes the NEW value (bypass). That frame is not an underrun, and the fresh flag ends cleared.
  - i_frame_stb coinciding with a completing i_sample_stb: the new value cannot be visible yet, so the frame latches the old o_sample. Fresh is evaluated before the update. Fresh ends set.
- i_mute only affects o_frame_sample. Accumulation and o_sample continue normally.
- Reset asserted mid-block: the partial block is discarded. The first output after release needs a full N strobes.

Optional Feature:
Macro SID_AUDIO_DCB_EN.
- Defined: a one-pole DC blocker follows the averager.
  - y = a - a_prev + y_prev - (y_prev >>> DCB_SHIFT), where a is the fresh average.
  - Internal width 18 bits signed; result saturated to [-32768, 32767] before driving o_sample.
  - Adds one pipeline stage: o_sample/o_sample_stb latency becomes 2 clocks from the final strobe.
  - a_prev and y_prev update only on a new average.
- Not defined: o_sample is the raw average with latency 1. No extra registers.

Test Plan:
- N=16, INPUT_SIGNED=0, 16 strobes of 0x8000 -> o_sample=0x0000; o_sample_stb pulses exactly 1 clock after the 16th strobe; nothing earlier.
- 16 strobes of 0xFFFF -> o_sample=0x7FFF. 16 strobes of 0x0000 -> 0x8000.
- 15 x 0x8000 then 1 x 0x7FFF -> sum -1, o_sample=0xFFFF (truncation toward -inf).
- Frame strobes and underrun:
  - i_frame_stb coinciding with the o_sample write cycle -> o_frame_sample = new value, o_underrun_cnt unchanged.
  - Two frame strobes with no block in between -> count +1 on the second only.
  - 300 empty frames -> count 255.
- Mute and reset:
  - i_mute=1 with o_sample=0x1234, then frame strobe -> o_frame_sample=0; o_sample still 0x1234.
  - Reset pulse after 7 strobes, then 16 strobes of 0xC000 -> single o_sample_stb with 0x4000.
- With SID_AUDIO_DCB_EN, constant 0xC000 blocks:
  - First output = 0x4000, latency 2.
  - Subsequent outputs decay monotonically toward 0; each step y -= y>>>8.

Source files
------------

// File: rtl/sid_audio_decimator.sv
// Block averager for SID samples feeding the I2S serializer: decimates by 2^DECIM_LOG2
// and holds a frame-stable sample. Define SID_AUDIO_DCB_EN to add a one-pole DC blocker.
module sid_audio_decimator #(
  parameter int DECIM_LOG2   = 4,
  parameter int INPUT_SIGNED = 0,
  parameter int DCB_SHIFT    = 8
) (
  input  logic        clk_25mhz,
  input  logic        rst_25mhz_n,
  input  logic [15:0] i_sample,
  input  logic        i_sample_stb,
  input  logic        i_frame_stb,
  input  logic        i_mute,
  output logic [15:0] o_sample,
  output logic        o_sample_stb,
  output logic [15:0] o_frame_sample,
  output logic [7:0]  o_underrun_cnt
);

  localparam int ACC_W = 16 + DECIM_LOG2;

  if (DECIM_LOG2 < 1 || DECIM_LOG2 > 8 || DCB_SHIFT < 1 || DCB_SHIFT > 17) begin : g_bad_param
    $error("sid_audio_decimator: DECIM_LOG2 must be 1..8 and DCB_SHIFT 1..17");
  end

  logic signed [15:0]      x;
  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] acc_p0;
  logic [DECIM_LOG2-1:0]   cnt_p0;
  logic                    blk_done;
  logic signed [15:0]      avg;
  logic                    upd;
  logic signed [15:0]      upd_val;
  logic                    fresh;

  // SID delivers offset binary; flipping the MSB turns it into two's complement
  always_comb begin
    if (INPUT_SIGNED != 0) x = i_sample;
    else                   x = {~i_sample[15], i_sample[14:0]};
  end

  assign x_ext    = {{DECIM_LOG2{x[15]}}, x};
  assign sum      = acc_p0 + x_ext;
  assign blk_done = i_sample_stb && (cnt_p0 == {DECIM_LOG2{1'b1}});
  assign avg      = 16'(sum >>> DECIM_LOG2);

  // Stage p0: block accumulator
  always_ff @(posedge clk_25mhz or negedge rst_25mhz_n) begin
    if (!rst_25mhz_n) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
    end else if (i_sample_stb) begin
      cnt_p0 <= cnt_p0 + 1'b1;
      acc_p0 <= blk_done ? '0 : sum;
    end
  end

`ifdef SID_AUDIO_DCB_EN
  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)       return 16'sh7FFF;
    else if (v < -18'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  logic signed [15:0] avg_p1;
  logic               vld_p1;
  logic signed [17:0] a_ext;
  logic signed [17:0] a_prev;
  logic signed [17:0] y_prev;
  logic signed [17:0] y_p1;

  // Stage p1: registered average, then the DC blocker
  always_ff @(posedge clk_25mhz or negedge rst_25mhz_n) begin
    if (!rst_25mhz_n) begin
      avg_p1 <= '0;
      vld_p1 <= 1'b0;
      a_prev <= '0;
      y_prev <= '0;
    end else begin
      vld_p1 <= blk_done;
      if (blk_done) avg_p1 <= avg;
      if (vld_p1) begin
        a_prev <= a_ext;
        y_prev <= y_p1;
      end
    end
  end

  assign a_ext   = {{2{avg_p1[15]}}, avg_p1};
  assign y_p1    = a_ext - a_prev + y_prev - (y_prev >>> DCB_SHIFT);
  assign upd     = vld_p1;
  assign upd_val = sat16(y_p1);
`else
  assign upd     = blk_done;
  assign upd_val = avg;
`endif

  // Output stage: o_sample and the fresh flag move together, so a frame strobe
  // landing on the o_sample_stb cycle sees the new value and no underrun
  always_ff @(posedge clk_25mhz or negedge rst_25mhz_n) begin
    if (!rst_25mhz_n) begin
      o_sample       <= '0;
      o_sample_stb   <= 1'b0;
      o_frame_sample <= '0;
      o_underrun_cnt <= '0;
      fresh          <= 1'b0;
    end else begin
      o_sample_stb <= upd;
      if (upd) o_sample <= upd_val;
      if (i_frame_stb) begin
        o_frame_sample <= i_mute ? 16'h0000 : o_sample;
        if (!fresh && o_underrun_cnt != 8'hFF) o_underrun_cnt <= o_underrun_cnt + 8'd1;
      end
      if (upd)              fresh <= 1'b1;
      else if (i_frame_stb) fresh <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sid_audio_decimator.sv
// Directed bench for sid_audio_decimator (default N=16, offset-binary input).
module tb_sid_audio_decimator;

  logic        clk_25mhz;
  logic        rst_25mhz_n;
  logic [15:0] i_sample;
  logic        i_sample_stb;
  logic        i_frame_stb;
  logic        i_mute;
  logic [15:0] o_sample;
  logic        o_sample_stb;
  logic [15:0] o_frame_sample;
  logic [7:0]  o_underrun_cnt;

  int checks = 0;
  int errors = 0;

  sid_audio_decimator dut (
    .clk_25mhz      (clk_25mhz),
    .rst_25mhz_n    (rst_25mhz_n),
    .i_sample       (i_sample),
    .i_sample_stb   (i_sample_stb),
    .i_frame_stb    (i_frame_stb),
    .i_mute         (i_mute),
    .o_sample       (o_sample),
    .o_sample_stb   (o_sample_stb),
    .o_frame_sample (o_frame_sample),
    .o_underrun_cnt (o_underrun_cnt)
  );

  initial clk_25mhz = 1'b0;
  always #20 clk_25mhz = ~clk_25mhz;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] first;
    logic [15:0] last;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change just after a falling edge; the DUT samples them on the next rising edge.
  task automatic push(input logic [15:0] v);
    i_sample     = v;
    i_sample_stb = 1'b1;
    @(negedge clk_25mhz);
    i_sample_stb = 1'b0;
  endtask

  task automatic frame(input logic mute);
    i_mute      = mute;
    i_frame_stb = 1'b1;
    @(negedge clk_25mhz);
    i_frame_stb = 1'b0;
    i_mute      = 1'b0;
  endtask

  // 15 strobes of 'first', one of 'last'; checks stb timing and the average.
  task automatic send_block(input string name, input logic [15:0] first,
                            input logic [15:0] last, input logic [15:0] exp);
    logic early;
    early = 1'b0;
    for (int i = 0; i < 15; i++) begin
      push(first);
      early |= o_sample_stb;
    end
    push(last);
    chk({name, " early_stb"}, 32'(early), 32'd0);
    chk({name, " stb"}, 32'(o_sample_stb), 32'd1);
    chk({name, " sample"}, 32'(o_sample), 32'(exp));
    @(negedge clk_25mhz);
    chk({name, " stb_one_cycle"}, 32'(o_sample_stb), 32'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " o_sample"}, 32'(o_sample), 32'd0);
    chk({name, " o_sample_stb"}, 32'(o_sample_stb), 32'd0);
    chk({name, " o_frame_sample"}, 32'(o_frame_sample), 32'd0);
    chk({name, " o_underrun_cnt"}, 32'(o_underrun_cnt), 32'd0);
  endtask

  initial begin
    vecs[0] = '{16'h8000, 16'h8000, 16'h0000};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 16'h7FFF};
    vecs[2] = '{16'h0000, 16'h0000, 16'h8000};
    vecs[3] = '{16'h8000, 16'h7FFF, 16'hFFFF};
    vecs[4] = '{16'hC000, 16'hC000, 16'h4000};
    vecs[5] = '{16'h4000, 16'h4000, 16'hC000};
    vecs[6] = '{16'h8001, 16'h8010, 16'h0001};
    vecs[7] = '{16'h7FFF, 16'h8000, 16'hFFFF};

    rst_25mhz_n  = 1'b0;
    i_sample     = '0;
    i_sample_stb = 1'b0;
    i_frame_stb  = 1'b0;
    i_mute       = 1'b0;
    repeat (3) @(negedge clk_25mhz);
    chk_all_zero("reset");
    rst_25mhz_n = 1'b1;
    @(negedge clk_25mhz);

`ifdef SID_AUDIO_DCB_EN
    begin
      logic [15:0] dcb_exp[3];
      dcb_exp[0] = 16'h4000;
      dcb_exp[1] = 16'h3FC0;
      dcb_exp[2] = 16'h3F81;
      for (int b = 0; b < 3; b++) begin
        logic early;
        early = 1'b0;
        for (int i = 0; i < 16; i++) begin
          push(16'hC000);
          early |= o_sample_stb;
        end
        chk($sformatf("dcb%0d early_stb", b), 32'(early), 32'd0);
        @(negedge clk_25mhz);
        chk($sformatf("dcb%0d stb", b), 32'(o_sample_stb), 32'd1);
        chk($sformatf("dcb%0d sample", b), 32'(o_sample), 32'(dcb_exp[b]));
        @(negedge clk_25mhz);
        chk($sformatf("dcb%0d stb_one_cycle", b), 32'(o_sample_stb), 32'd0);
      end
    end
`else
    for (int v = 0; v < 8; v++)
      send_block($sformatf("vec%0d", v), vecs[v].first, vecs[v].last, vecs[v].exp);

    // fresh is set by the last block, so this frame is not an underrun
    frame(1'b0);
    chk("frame_after_table sample", 32'(o_frame_sample), 32'h0000FFFF);
    chk("frame_after_table underrun", 32'(o_underrun_cnt), 32'd0);

    // frame strobe on the o_sample_stb cycle takes the new value
    for (int i = 0; i < 15; i++) push(16'h8000);
    push(16'hA000);
    chk("bypass stb", 32'(o_sample_stb), 32'd1);
    frame(1'b0);
    chk("bypass frame_sample", 32'(o_frame_sample), 32'h00000200);
    chk("bypass underrun", 32'(o_underrun_cnt), 32'd0);

    frame(1'b0);
    chk("second_frame underrun", 32'(o_underrun_cnt), 32'd1);
    chk("second_frame sample", 32'(o_frame_sample), 32'h00000200);

    // frame strobe together with the completing sample strobe latches the old value
    for (int i = 0; i < 15; i++) push(16'h8000);
    i_sample     = 16'hE000;
    i_sample_stb = 1'b1;
    i_frame_stb  = 1'b1;
    @(negedge clk_25mhz);
    i_sample_stb = 1'b0;
    i_frame_stb  = 1'b0;
    chk("coincide frame_sample", 32'(o_frame_sample), 32'h00000200);
    chk("coincide underrun", 32'(o_underrun_cnt), 32'd2);
    chk("coincide o_sample", 32'(o_sample), 32'h00000600);
    frame(1'b0);
    chk("coincide_next underrun", 32'(o_underrun_cnt), 32'd2);
    chk("coincide_next sample", 32'(o_frame_sample), 32'h00000600);

    send_block("mute_setup", 16'h9234, 16'h9234, 16'h1234);
    frame(1'b1);
    chk("mute frame_sample", 32'(o_frame_sample), 32'd0);
    chk("mute o_sample", 32'(o_sample), 32'h00001234);
    chk("mute underrun", 32'(o_underrun_cnt), 32'd2);

    // reset in the middle of a block discards the partial sum
    for (int i = 0; i < 7; i++) push(16'hFFFF);
    rst_25mhz_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk_25mhz);
    rst_25mhz_n = 1'b1;
    @(negedge clk_25mhz);
    frame(1'b0);
    chk("first_frame_after_reset underrun", 32'(o_underrun_cnt), 32'd1);
    send_block("after_reset", 16'hC000, 16'hC000, 16'h4000);

    for (int i = 0; i < 100; i++) frame(1'b0);
    chk("empty_frames_100 underrun", 32'(o_underrun_cnt), 32'd100);
    for (int i = 0; i < 200; i++) frame(1'b0);
    chk("empty_frames_300 underrun", 32'(o_underrun_cnt), 32'd255);
    chk("empty_frames sample", 32'(o_frame_sample), 32'h00004000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
